// File: rtl/fp32_mul_ctrl.sv
// IEEE-754 single-precision multiply sequencer around a shared external integer multiplier.
// Unpacks operands, drives the multiplier for MUL_LAT cycles, then normalises, rounds (RNE) and packs.
module fp32_mul_ctrl #(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [3:0]  flags,
  output logic [31:0] mul_q,
  output logic [31:0] mul_m,
  input  logic [63:0] mul_p
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_NORM,
    S_ROUND,
    S_HOLD
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_sign;
  logic [7:0]          r_ea;
  logic [7:0]          r_eb;
  logic [47:0]         r_p;
  logic signed [9:0]   r_e;
  logic [22:0]         r_mant;
  logic                r_guard;
  logic                r_sticky;
  logic                r_out_valid;
  logic [31:0]         r_result;
  logic [3:0]          r_flags;
  logic [31:0]         r_mul_q;
  logic [31:0]         r_mul_m;

  logic [7:0]          w_ea;
  logic [7:0]          w_eb;
  logic [22:0]         w_fa;
  logic [22:0]         w_fb;
  logic                w_sign;
  logic                w_a_zero, w_a_inf, w_a_nan;
  logic                w_b_zero, w_b_inf, w_b_nan;
  logic                w_special;
  logic [31:0]         w_spec_result;
  logic                w_spec_invalid;
  logic signed [9:0]   w_e_sum;
  logic                w_round_up;
  logic [23:0]         w_mant_rnd;
  logic signed [9:0]   w_e_rnd;
  logic                w_inexact;
  logic                w_unused;

  assign w_ea   = a[30:23];
  assign w_eb   = b[30:23];
  assign w_fa   = a[22:0];
  assign w_fb   = b[22:0];
  assign w_sign = a[31] ^ b[31];

  // Denormal inputs count as zero: any exponent of 0 is a zero operand.
  assign w_a_zero = (w_ea == 8'h00);
  assign w_b_zero = (w_eb == 8'h00);
  assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == '0);
  assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == '0);
  assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != '0);
  assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != '0);
  assign w_special = w_a_zero | w_b_zero | w_a_inf | w_b_inf | w_a_nan | w_b_nan;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    w_spec_result  = {w_sign, 31'b0};
    w_spec_invalid = 1'b0;
    if (w_a_nan || w_b_nan) begin
      w_spec_result  = 32'h7FC0_0000;
      w_spec_invalid = (w_a_nan && !w_fa[22]) || (w_b_nan && !w_fb[22]);
    end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
      w_spec_result  = 32'h7FC0_0000;
      w_spec_invalid = 1'b1;
    end else if (w_a_inf || w_b_inf) begin
      w_spec_result  = {w_sign, 8'hFF, 23'b0};
    end
  end

  assign w_e_sum    = $signed({2'b00, r_ea}) + $signed({2'b00, r_eb}) - 10'sd127;
  assign w_round_up = r_guard & (r_sticky | r_mant[0]);
  assign w_mant_rnd = {1'b0, r_mant} + {23'b0, w_round_up};
  // A carry out of the mantissa leaves the low 23 bits at zero and bumps the exponent.
  assign w_e_rnd    = r_e + $signed({9'b0, w_mant_rnd[23]});
  assign w_inexact  = r_guard | r_sticky;

  assign w_unused = ^mul_p[63:48];

  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sign      <= 1'b0;
      r_ea        <= '0;
      r_eb        <= '0;
      r_p         <= '0;
      r_e         <= '0;
      r_mant      <= '0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_mul_q     <= '0;
      r_mul_m     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign <= w_sign;
            r_ea   <= w_ea;
            r_eb   <= w_eb;
            if (w_special) begin
              r_result    <= w_spec_result;
              r_flags     <= {w_spec_invalid, 3'b000};
              r_out_valid <= 1'b1;
              r_state     <= S_HOLD;
            end else begin
              r_mul_q <= {8'b0, 1'b1, w_fa};
              r_mul_m <= {8'b0, 1'b1, w_fb};
              r_cnt   <= CW'(MUL_LAT - 1);
              r_state <= S_MUL;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == '0) begin
            r_p     <= mul_p[47:0];
            r_state <= S_NORM;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_NORM: begin
          if (r_p[47]) begin
            r_e      <= w_e_sum + 10'sd1;
            r_mant   <= r_p[46:24];
            r_guard  <= r_p[23];
            r_sticky <= |r_p[22:0];
          end else begin
            r_e      <= w_e_sum;
            r_mant   <= r_p[45:23];
            r_guard  <= r_p[22];
            r_sticky <= |r_p[21:0];
          end
          r_state <= S_ROUND;
        end
        S_ROUND: begin
          if (w_e_rnd >= 10'sd255) begin
            r_result <= {r_sign, 8'hFF, 23'b0};
            r_flags  <= 4'b0101;
          end else if (w_e_rnd <= 10'sd0) begin
            r_result <= {r_sign, 31'b0};
            r_flags  <= 4'b0011;
          end else begin
            r_result <= {r_sign, w_e_rnd[7:0], w_mant_rnd[22:0]};
            r_flags  <= {3'b000, w_inexact};
          end
          r_out_valid <= 1'b1;
          r_state     <= S_HOLD;
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Ready drops combinationally with rst so nothing is accepted during the reset cycle.
  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign flags     = r_flags;
  assign mul_q     = r_mul_q;
  assign mul_m     = r_mul_m;

endmodule
